muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  input  logic             flush
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic [31:0]      m_q, m_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_q, res_d;

  logic        sgn_a, sgn_b, sa, sb, neg_in;
  logic [31:0] mag_a, mag_b;
  logic        b_zero, ovf;
  logic [31:0] spec_res;

  assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = res_q;
  assign resp_tag   = tag_q;

  always_comb begin
    sgn_a  = req_op[2] ? !req_op[0] : (req_op != 3'b011);
    sgn_b  = req_op[2] ? !req_op[0] : !req_op[1];
    sa     = sgn_a && req_a[31];
    sb     = sgn_b && req_b[31];
    mag_a  = sa ? (~req_a + 32'd1) : req_a;
    mag_b  = sb ? (~req_b + 32'd1) : req_b;
    // remainder follows the dividend, everything else the xor of signs
    neg_in = (req_op[2] && req_op[1]) ? sa : (sa ^ sb);
    b_zero = req_op[2] && (req_b == 32'd0);
    ovf    = req_op[2] && !req_op[0] &&
             (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    if (b_zero)
      spec_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
    else
      spec_res = req_op[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fp_mag, fp;
  logic [31:0] fast_res;
  always_comb begin
    fp_mag   = {32'd0, mag_a} * {32'd0, mag_b};
    fp       = neg_in ? (~fp_mag + 64'd1) : fp_mag;
    fast_res = (req_op[1:0] == 2'b00) ? fp[31:0] : fp[63:32];
  end
`endif

  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic        div_ok;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod, prod_s;
  logic [31:0] div_raw, fin_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    div_sh   = {hi_q, lo_q[31]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = !div_diff[32];
    if (op_q[2]) begin
      hi_n = div_ok ? div_diff[31:0] : div_sh[31:0];
      lo_n = {lo_q[30:0], div_ok};
    end else begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo_q[31:1]};
    end
    prod    = {hi_n, lo_n};
    prod_s  = neg_q ? (~prod + 64'd1) : prod;
    div_raw = op_q[1] ? hi_n : lo_n;
    if (op_q[2])
      fin_res = neg_q ? (~div_raw + 32'd1) : div_raw;
    else
      fin_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_d  = req_op;
            tag_d = req_tag;
            neg_d = neg_in;
            cnt_d = 5'd0;
            hi_d  = 32'd0;
            m_d   = req_op[2] ? mag_b : mag_a;
            lo_d  = req_op[2] ? mag_a : mag_b;
            if (b_zero || ovf) begin
              res_d   = spec_res;
              state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!req_op[2]) begin
              res_d   = fast_res;
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic RV32M reference.
// Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             flush;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .busy(busy), .flush(flush)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pv;
    int qi, ri;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      default: p = 0;
    endcase
    pv = p;
    if (op == 3'd0) return pv[31:0];
    if (op < 3'd4) return pv[63:32];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      qi = $signed(a) / $signed(b);
      ri = $signed(a) % $signed(b);
      return op[1] ? ri : qi;
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if (op == 3'd4 || op == 3'd6)
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] er;
    logic [TAG_W-1:0] et;
    logic [31:0] d0;
    int g;
    g = 0;
    while (!req_ready && g < 100) begin tick(); g++; end
    check("ready_wait", {63'd0, req_ready}, 64'd1);
    er = ref_res(op, a, b);
    et = TAG_W'($urandom);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_tag = et;
    tick();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    req_op = 3'($urandom); req_tag = TAG_W'($urandom);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      check("busy_calc", {63'd0, busy}, 64'd1);
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(ref_lat(op, a, b)));
    check("data", {32'd0, resp_data}, {32'd0, er});
    check("tag", 64'(resp_tag), 64'(et));
    d0 = resp_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_data", {32'd0, resp_data}, {32'd0, d0});
      check("hold_tag", 64'(resp_tag), 64'(et));
      check("hold_busy", {63'd0, busy}, 64'd1);
      check("hold_rdy", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("post_valid", {63'd0, resp_valid}, 64'd0);
    check("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  task automatic abort_op(input bit use_rst);
    int seen;
    req_valid = 1'b1;
    req_op = 3'd1; req_a = $urandom; req_b = $urandom;
    req_tag = 5'h15;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_valid", {63'd0, resp_valid}, 64'd0);
    if (use_rst) begin
      check("rst_rdy", {63'd0, req_ready}, 64'd0);
      check("rst_data", {32'd0, resp_data}, 64'd0);
      check("rst_tag", 64'(resp_tag), 64'd0);
    end
    rst = 1'b0;
    flush = 1'b0;
    #1;
    check("abort_rdy", {63'd0, req_ready}, 64'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (resp_valid) seen++;
    end
    check("abort_noresp", 64'(seen), 64'd0);
  endtask

  logic [31:0] pool [8];

  initial begin
    logic [31:0] a, b;
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001;
    pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
    pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h0000_0002;
    pool[6] = 32'hFFFF_FFF9; pool[7] = 32'h0000_1234;
    rst = 1'b1; flush = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; req_tag = '0;
    tick(); tick();
    check("rst_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_data0", {32'd0, resp_data}, 64'd0);
    check("rst_tag0", 64'(resp_tag), 64'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {63'd0, req_ready}, 64'd1);

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd5, 32'h0000_1234, 32'd0, 0);
    run_op(3'd7, 32'h0000_1234, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op(3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5);

    abort_op(1'b0);
    abort_op(1'b1);

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(3) == 0) ? pool[$urandom_range(7)] : $urandom;
      b = ($urandom_range(3) == 0) ? pool[$urandom_range(7)] : $urandom;
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      run_op(3'($urandom), a, b, $urandom_range(2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
